ann_threshold_arbiter: RTL and testbench

- Round-robin arbiter sharing one ANN threshold stage among NUM_REQ ANN output channels (one per parallel neuron-output/window pipeline).
- Accepts one logsig result at a time and issues it to the threshold stage as a single-cycle input pulse.
- Waits for the stage's output-ready pulse, then returns flag and data tagged with the requester id.

---
 rtl/ann_threshold_arbiter_if.sv | 37 +++
 rtl/ann_threshold_arbiter.sv | 164 ++++++++++++++++
 tb/tb_ann_threshold_arbiter.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/ann_threshold_arbiter_if.sv
// ann_threshold_arbiter_if
// Groups the requester-side and threshold-stage-side signals of the shared
// ANN threshold arbiter. "slave" is the arbiter's view; "master" is the view
// of the environment (requesting channels plus the threshold stage).
interface ann_threshold_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]    iReq;
    logic [NUM_REQ*32-1:0] iData;
    logic [NUM_REQ-1:0]    oGrant;
    logic                  oTh_input_ready;
    logic [31:0]           oTh_data;
    logic                  iTh_output_ready;
    logic                  iTh_flag;
    logic [31:0]           iTh_data;
    logic                  oResult_valid;
    logic [ID_W-1:0]       oResult_id;
    logic                  oResult_flag;
    logic [31:0]           oResult_data;
    logic                  oResult_err;
    logic                  oBusy;

    modport slave (
        input  iReq, iData, iTh_output_ready, iTh_flag, iTh_data,
        output oGrant, oTh_input_ready, oTh_data,
               oResult_valid, oResult_id, oResult_flag, oResult_data,
               oResult_err, oBusy
    );

    modport master (
        output iReq, iData, iTh_output_ready, iTh_flag, iTh_data,
        input  oGrant, oTh_input_ready, oTh_data,
               oResult_valid, oResult_id, oResult_flag, oResult_data,
               oResult_err, oBusy
    );
endinterface

// File: rtl/ann_threshold_arbiter.sv
// ann_threshold_arbiter
// Round-robin arbiter sharing one ANN threshold stage among NUM_REQ channels.
// One logsig value is issued at a time as an isolated start pulse; the
// stage's result is returned tagged with the owning channel id.
// Optional WAIT watchdog: define ANN_THRESHOLD_ARBITER_TIMEOUT_EN.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | no transaction; arbitrate among pending requests
// S_ISSUE | grant and start pulse are high for this single cycle
// S_WAIT  | waiting for the threshold stage's output-ready pulse
module ann_threshold_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ID_W           = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    iClk,
    input  logic                    iReset_n,
    ann_threshold_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    if ((2 ** ID_W) < NUM_REQ || NUM_REQ < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("ann_threshold_arbiter: illegal NUM_REQ/ID_W/TIMEOUT_CYCLES combination");
    end

    state_t              state_q;
    logic [ID_W-1:0]     ptr_q;
    logic [ID_W-1:0]     lat_id_q;
    logic [NUM_REQ-1:0]  grant_q;
    logic                start_q;
    logic [31:0]         th_data_q;
    logic                res_valid_q;
    logic [ID_W-1:0]     res_id_q;
    logic                res_flag_q;
    logic [31:0]         res_data_q;
    logic                busy_q;

    logic                pick_vld;
    logic [ID_W-1:0]     pick_id;
    logic [ID_W-1:0]     idx;
    logic [31:0]         pick_data;

`ifdef ANN_THRESHOLD_ARBITER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]    cnt_q;
    logic                res_err_q;
`endif

    // Round-robin search: first pending request above the pointer, wrapping.
    always_comb begin
        pick_vld = 1'b0;
        pick_id  = '0;
        idx      = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = ID_W'((int'(ptr_q) + i) % NUM_REQ);
            if (!pick_vld && bus.iReq[idx]) begin
                pick_vld = 1'b1;
                pick_id  = idx;
            end
        end
    end

    // Select the winning channel's logsig slice.
    always_comb begin
        pick_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (pick_id == ID_W'(k)) begin
                pick_data = bus.iData[32*k +: 32];
            end
        end
    end

    // Control FSM; every output is a register updated here.
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            state_q     <= S_IDLE;
            ptr_q       <= ID_W'(NUM_REQ - 1);
            lat_id_q    <= '0;
            grant_q     <= '0;
            start_q     <= 1'b0;
            th_data_q   <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_flag_q  <= 1'b0;
            res_data_q  <= '0;
            busy_q      <= 1'b0;
`ifdef ANN_THRESHOLD_ARBITER_TIMEOUT_EN
            cnt_q       <= '0;
            res_err_q   <= 1'b0;
`endif
        end else begin
            grant_q     <= '0;
            start_q     <= 1'b0;
            res_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pick_vld) begin
                        lat_id_q  <= pick_id;
                        ptr_q     <= pick_id;
                        th_data_q <= pick_data;
                        grant_q   <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_id;
                        start_q   <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
`ifdef ANN_THRESHOLD_ARBITER_TIMEOUT_EN
                    cnt_q   <= '0;
`endif
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.iTh_output_ready) begin
                        res_valid_q <= 1'b1;
                        res_id_q    <= lat_id_q;
                        res_flag_q  <= bus.iTh_flag;
                        res_data_q  <= bus.iTh_data;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
`ifdef ANN_THRESHOLD_ARBITER_TIMEOUT_EN
                        res_err_q   <= 1'b0;
                    end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
                        res_valid_q <= 1'b1;
                        res_id_q    <= lat_id_q;
                        res_flag_q  <= 1'b0;
                        res_data_q  <= '0;
                        res_err_q   <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end else begin
                        cnt_q       <= cnt_q + 1'b1;
`endif
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.oGrant          = grant_q;
    assign bus.oTh_input_ready = start_q;
    assign bus.oTh_data        = th_data_q;
    assign bus.oResult_valid   = res_valid_q;
    assign bus.oResult_id      = res_id_q;
    assign bus.oResult_flag    = res_flag_q;
    assign bus.oResult_data    = res_data_q;
    assign bus.oBusy           = busy_q;
`ifdef ANN_THRESHOLD_ARBITER_TIMEOUT_EN
    assign bus.oResult_err     = res_err_q;
`else
    assign bus.oResult_err     = 1'b0;
`endif

endmodule

// File: tb/tb_ann_threshold_arbiter.sv
// tb_ann_threshold_arbiter
// Directed bench for ann_threshold_arbiter; the threshold stage is played by
// the stimulus sequence itself (ready two cycles after each start pulse).
`timescale 1ns/1ps
module tb_ann_threshold_arbiter;
    localparam int NUM_REQ        = 4;
    localparam int ID_W           = 2;
    localparam int TIMEOUT_CYCLES = 16;

    logic iClk     = 1'b0;
    logic iReset_n = 1'b0;
    int   checks   = 0;
    int   errors   = 0;
    int   cyc      = 0;

    ann_threshold_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

    ann_threshold_arbiter #(
        .NUM_REQ(NUM_REQ), .ID_W(ID_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .iClk(iClk), .iReset_n(iReset_n), .bus(bus)
    );

    always #5 iClk = ~iClk;
    always @(posedge iClk) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "bench timeout");
    end

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grant"},  32'(bus.oGrant),          0);
        chk({tag, "_start"},  32'(bus.oTh_input_ready), 0);
        chk({tag, "_thdata"}, bus.oTh_data,             0);
        chk({tag, "_valid"},  32'(bus.oResult_valid),   0);
        chk({tag, "_id"},     32'(bus.oResult_id),      0);
        chk({tag, "_flag"},   32'(bus.oResult_flag),    0);
        chk({tag, "_data"},   bus.oResult_data,         0);
        chk({tag, "_err"},    32'(bus.oResult_err),     0);
        chk({tag, "_busy"},   32'(bus.oBusy),           0);
    endtask

    // Full transaction from the IDLE cycle in which req is sampled (cycle 0)
    // up to the result cycle (cycle 4); returns in cycle 4.
    task automatic run_txn(input string tag, input logic [3:0] req, input int exp_id,
                           input logic [31:0] exp_dat, input logic rflag,
                           input logic [31:0] rdata, input logic [3:0] req_after,
                           output int res_cyc);
        logic [3:0] g;
        g = 4'b0001 << exp_id;
        bus.iReq = req;
        tick();
        chk({tag, "_grant"},  32'(bus.oGrant),          32'(g));
        chk({tag, "_start"},  32'(bus.oTh_input_ready), 1);
        chk({tag, "_thdata"}, bus.oTh_data,             exp_dat);
        chk({tag, "_busy1"},  32'(bus.oBusy),           1);
        bus.iReq = req_after;
        tick();
        chk({tag, "_grant_off"}, 32'(bus.oGrant),          0);
        chk({tag, "_start_off"}, 32'(bus.oTh_input_ready), 0);
        chk({tag, "_busy2"},     32'(bus.oBusy),           1);
        tick();
        chk({tag, "_early_valid"}, 32'(bus.oResult_valid), 0);
        bus.iTh_output_ready = 1'b1;
        bus.iTh_flag         = rflag;
        bus.iTh_data         = rdata;
        tick();
        bus.iTh_output_ready = 1'b0;
        bus.iTh_flag         = 1'b0;
        bus.iTh_data         = '0;
        chk({tag, "_valid"},  32'(bus.oResult_valid), 1);
        chk({tag, "_id"},     32'(bus.oResult_id),    32'(exp_id));
        chk({tag, "_flag"},   32'(bus.oResult_flag),  32'(rflag));
        chk({tag, "_data"},   bus.oResult_data,       rdata);
        chk({tag, "_err"},    32'(bus.oResult_err),   0);
        chk({tag, "_busy4"},  32'(bus.oBusy),         0);
        chk({tag, "_thhold"}, bus.oTh_data,           exp_dat);
        res_cyc = cyc;
    endtask

    initial begin
        int rc;
        int prev_rc;
        bus.iReq             = '0;
        bus.iData            = '0;
        bus.iTh_output_ready = 1'b0;
        bus.iTh_flag         = 1'b0;
        bus.iTh_data         = '0;

        // Reset values
        #12;
        chk_all_zero("reset");
        @(negedge iClk);
        iReset_n = 1'b1;
        tick();
        chk_all_zero("post_reset");

        // Single request on channel 0
        bus.iData[31:0] = 32'h0090_0000;
        run_txn("single", 4'b0001, 0, 32'h0090_0000, 1'b0, 32'h0090_0000, 4'b0000, rc);

        // Pointer moves to 1, then 0011 must wrap to channel 0
        bus.iData[63:32] = 32'hAAAA_0001;
        run_txn("fair_a", 4'b0010, 1, 32'hAAAA_0001, 1'b1, 32'h1234_5678, 4'b0000, rc);
        bus.iData[31:0] = 32'h0BAD_0000;
        run_txn("fair_b", 4'b0011, 0, 32'h0BAD_0000, 1'b0, 32'h0000_00FF, 4'b0000, rc);

        // Spurious ready in IDLE produces nothing and results hold
        bus.iReq             = '0;
        bus.iTh_output_ready = 1'b1;
        bus.iTh_flag         = 1'b1;
        bus.iTh_data         = 32'hDEAD_BEEF;
        tick();
        bus.iTh_output_ready = 1'b0;
        bus.iTh_flag         = 1'b0;
        bus.iTh_data         = '0;
        chk("spur_valid", 32'(bus.oResult_valid), 0);
        chk("spur_busy",  32'(bus.oBusy),         0);
        chk("spur_grant", 32'(bus.oGrant),        0);
        chk("spur_hold",  bus.oResult_data,       32'h0000_00FF);
        tick();
        chk("spur_valid2", 32'(bus.oResult_valid), 0);
        chk("spur_busy2",  32'(bus.oBusy),         0);

        // Contention: park pointer at 3, then all four request continuously
        for (int k = 0; k < NUM_REQ; k++) bus.iData[32*k +: 32] = 32'hC0DE_0000 + 32'(k);
        run_txn("park", 4'b1000, 3, 32'hC0DE_0003, 1'b0, 32'h0000_0003, 4'b1111, rc);
        prev_rc = 0;
        for (int i = 0; i < 5; i++) begin
            run_txn("rr", 4'b1111, i % 4, 32'hC0DE_0000 + 32'(i % 4), 1'(i),
                    32'h5000_0000 + 32'(i % 4), 4'b1111, rc);
            if (i > 0) chk("rr_spacing", 32'(rc - prev_rc), 4);
            prev_rc = rc;
        end
        bus.iReq = '0;
        tick();

        // Reset during WAIT discards the transaction
        bus.iData[95:64] = 32'h2222_0000;
        bus.iReq = 4'b0100;
        tick();
        chk("mid_grant", 32'(bus.oGrant), 32'h4);
        bus.iReq = '0;
        tick();
        chk("mid_busy", 32'(bus.oBusy), 1);
        iReset_n = 1'b0;
        bus.iTh_output_ready = 1'b1;
        bus.iTh_data = 32'h3333_3333;
        #1;
        chk_all_zero("mid_reset");
        @(negedge iClk);
        bus.iTh_output_ready = 1'b0;
        bus.iTh_data = '0;
        iReset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mid_no_stale", 32'(bus.oResult_valid), 0);
            chk("mid_idle",     32'(bus.oBusy),         0);
        end
        bus.iData[63:32] = 32'h1111_0001;
        run_txn("after_rst", 4'b0010, 1, 32'h1111_0001, 1'b1, 32'h1111_F000, 4'b0000, rc);

        // WAIT with a silent stage
        bus.iData[31:0] = 32'h0777_0000;
        bus.iReq = 4'b0001;
        tick();
        chk("to_grant", 32'(bus.oGrant), 32'h1);
        bus.iReq = '0;
        tick();
`ifdef ANN_THRESHOLD_ARBITER_TIMEOUT_EN
        repeat (TIMEOUT_CYCLES) tick();
        chk("to_not_yet", 32'(bus.oResult_valid), 0);
        chk("to_busy",    32'(bus.oBusy),         1);
        tick();
        chk("to_valid", 32'(bus.oResult_valid), 1);
        chk("to_err",   32'(bus.oResult_err),   1);
        chk("to_data",  bus.oResult_data,       0);
        chk("to_flag",  32'(bus.oResult_flag),  0);
        chk("to_id",    32'(bus.oResult_id),    0);
        chk("to_idle",  32'(bus.oBusy),         0);
        bus.iTh_output_ready = 1'b1;
        bus.iTh_data         = 32'h5A5A_5A5A;
        tick();
        bus.iTh_output_ready = 1'b0;
        bus.iTh_data         = '0;
        chk("late_valid", 32'(bus.oResult_valid), 0);
        chk("late_data",  bus.oResult_data,       0);
`else
        repeat (TIMEOUT_CYCLES + 4) tick();
        chk("nowd_valid", 32'(bus.oResult_valid), 0);
        chk("nowd_busy",  32'(bus.oBusy),         1);
        chk("nowd_err",   32'(bus.oResult_err),   0);
        bus.iTh_output_ready = 1'b1;
        bus.iTh_flag         = 1'b1;
        bus.iTh_data         = 32'h0777_AAAA;
        tick();
        bus.iTh_output_ready = 1'b0;
        bus.iTh_flag         = 1'b0;
        bus.iTh_data         = '0;
        chk("nowd_res_valid", 32'(bus.oResult_valid), 1);
        chk("nowd_res_id",    32'(bus.oResult_id),    0);
        chk("nowd_res_data",  bus.oResult_data,       32'h0777_AAAA);
        chk("nowd_res_err",   32'(bus.oResult_err),   0);
`endif
        tick();
        chk("final_idle", 32'(bus.oBusy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
